// File: rtl/i2c_fan_target.sv
// I2C target emulating the fan-controller chip: filtered bus inputs, START/STOP decode, small register file, alert output.
// Define FAN_TARGET_AUTOINC_EN to advance the register pointer after every data byte written or read.
module i2c_fan_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1B,
  parameter int         FILTER_LEN = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic [7:0] SPEED_REG,
  output logic [7:0] CONFIG_REG,
  input  logic [7:0] TACH0,
  input  logic [7:0] TACH1,
  input  logic [3:0] ALARM_SET,
  output logic       ALERT_N,
  output logic       BUSY
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA through synchroniser and filter.
  logic [1:0]    sync_p0, sync_p1, flt, flt_d;
  logic [CW-1:0] flt_cnt [2];

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, ptr, ptr_next, rd_byte;
  logic [3:0] alarm, alarm_en;
  logic       rw, mack;
  logic       scl_rise, scl_fall, start_det, stop_det, load_now, alarm_clr;

  // Synchroniser stage, then the glitch filter stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
      flt     <= 2'b11;
      flt_d   <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync_p0 <= {SCL_IN, SDA_IN};
      sync_p1 <= sync_p0;
      flt_d   <= flt;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == flt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
          flt[i]     <= sync_p1[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise  = flt[1] & ~flt_d[1];
  assign scl_fall  = ~flt[1] & flt_d[1];
  assign start_det = flt[1] & flt_d[1] & ~flt[0] & flt_d[0];
  assign stop_det  = flt[1] & flt_d[1] & flt[0] & ~flt_d[0];

`ifdef FAN_TARGET_AUTOINC_EN
  assign ptr_next = ptr + 8'd1;
`else
  assign ptr_next = ptr;
`endif

  always_comb begin
    rd_byte = 8'hFF;
    case (ptr)
      8'h00:   rd_byte = SPEED_REG;
      8'h02:   rd_byte = CONFIG_REG;
      8'h08:   rd_byte = {4'h0, alarm_en};
      8'h0C:   rd_byte = TACH0;
      8'h0E:   rd_byte = TACH1;
      8'h12:   rd_byte = {4'h0, alarm};
      default: rd_byte = 8'hFF;
    endcase
  end

  // The read shifter loads at the end of an address ACK or a master ACK; ALARM clears on that load.
  assign load_now  = scl_fall && ((state == ADDR_ACK && rw) || (state == RACK && !mack));
  assign alarm_clr = load_now && (ptr == 8'h12);

  // Protocol FSM and register file stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      ptr        <= 8'h00;
      rw         <= 1'b0;
      mack       <= 1'b1;
      SDA_OE     <= 1'b0;
      BUSY       <= 1'b0;
      ALERT_N    <= 1'b1;
      SPEED_REG  <= 8'h00;
      CONFIG_REG <= 8'h0A;
      alarm      <= 4'h0;
      alarm_en   <= 4'h0;
    end else begin
      alarm   <= (alarm_clr ? 4'h0 : alarm) | ALARM_SET;
      ALERT_N <= ~|(alarm & alarm_en);
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        SDA_OE  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        SDA_OE <= 1'b0;
        BUSY   <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], flt[0]};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (state == ADDR) begin
                if (shreg[7:1] == SLAVE_ADDR) begin
                  state  <= ADDR_ACK;
                  rw     <= shreg[0];
                  BUSY   <= 1'b1;
                  SDA_OE <= 1'b1;
                end else begin
                  state <= WAIT;
                  BUSY  <= 1'b0;
                end
              end else if (state == PTR) begin
                ptr    <= shreg;
                state  <= PTR_ACK;
                SDA_OE <= 1'b1;
              end else begin
                state  <= WDATA_ACK;
                SDA_OE <= 1'b1;
              end
            end
          end
          ADDR_ACK, RACK: begin
            if (scl_rise) begin
              mack <= flt[0];
            end else if (load_now) begin
              state   <= RDATA;
              shreg   <= rd_byte;
              SDA_OE  <= ~rd_byte[7];
              ptr     <= ptr_next;
              bit_cnt <= 4'd0;
            end else if (scl_fall) begin
              state   <= (state == ADDR_ACK) ? PTR : WAIT;
              SDA_OE  <= 1'b0;
              bit_cnt <= 4'd0;
            end
          end
          PTR_ACK: begin
            if (scl_fall) begin
              state  <= WDATA;
              SDA_OE <= 1'b0;
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              case (ptr)
                8'h00:   SPEED_REG  <= shreg;
                8'h02:   CONFIG_REG <= shreg;
                8'h08:   alarm_en   <= shreg[3:0];
                default: ;
              endcase
              ptr    <= ptr_next;
              state  <= WDATA;
              SDA_OE <= 1'b0;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                state  <= RACK;
                SDA_OE <= 1'b0;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                SDA_OE <= ~shreg[6];
              end
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_fan_target.sv
// Bench for i2c_fan_target: bit-banged I2C master with directed and randomized transactions checked against a register-level model.
module tb_i2c_fan_target;
  localparam int Q = 10;
`ifdef FAN_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl, m_sda;
  wire        sda_bus;
  logic       sda_oe;
  logic [7:0] speed, config_r, tach0, tach1;
  logic [3:0] alarm_set;
  logic       alert_n, busy;

  always #5 clk = ~clk;
  assign sda_bus = m_sda & ~sda_oe;

  i2c_fan_target dut (
    .CLK(clk), .RST_N(rst_n), .SCL_IN(m_scl), .SDA_IN(sda_bus), .SDA_OE(sda_oe),
    .SPEED_REG(speed), .CONFIG_REG(config_r), .TACH0(tach0), .TACH1(tach1),
    .ALARM_SET(alarm_set), .ALERT_N(alert_n), .BUSY(busy)
  );

  int oe_count = 0;
  always @(posedge clk) if (sda_oe === 1'b1) oe_count <= oe_count + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-level reference model
  logic [7:0] md_speed, md_config, md_ptr;
  logic [3:0] md_alarm, md_alarm_en;
  logic [7:0] wbuf [4];

  task automatic model_reset();
    md_speed = 8'h00; md_config = 8'h0A; md_ptr = 8'h00;
    md_alarm = 4'h0;  md_alarm_en = 4'h0;
  endtask

  task automatic model_write(input logic [7:0] d);
    case (md_ptr)
      8'h00: md_speed = d;
      8'h02: md_config = d;
      8'h08: md_alarm_en = d[3:0];
      default: ;
    endcase
    if (AUTOINC) md_ptr = md_ptr + 8'd1;
  endtask

  task automatic model_read(output logic [7:0] e);
    case (md_ptr)
      8'h00: e = md_speed;
      8'h02: e = md_config;
      8'h08: e = {4'h0, md_alarm_en};
      8'h0C: e = tach0;
      8'h0E: e = tach1;
      8'h12: begin e = {4'h0, md_alarm}; md_alarm = 4'h0; end
      default: e = 8'hFF;
    endcase
    if (AUTOINC) md_ptr = md_ptr + 8'd1;
  endtask

  function automatic logic model_alert_n();
    return ((md_alarm & md_alarm_en) == 4'h0);
  endfunction

  // Bit-level master
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    if (!m_scl) begin m_scl = 1'b1; wait_q(); end
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = sda_bus; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin get_bit(b); d[i] = b; end
    put_bit(nack);
  endtask

  // Transaction level
  task automatic addr_phase(input logic [6:0] a, input logic r, output logic ok);
    logic ack;
    bus_start();
    put_byte({a, r}, ack);
    ok = (a == 7'h1B);
    check_eq("addr_ack", ack, !ok);
    check_eq("busy_after_addr", busy, ok);
  endtask

  task automatic write_txn(input logic [6:0] a, input logic [7:0] p, input int n);
    logic ok, ack;
    addr_phase(a, 1'b0, ok);
    if (ok) begin
      put_byte(p, ack); check_eq("ptr_ack", ack, 1'b0);
      md_ptr = p;
      for (int i = 0; i < n; i++) begin
        put_byte(wbuf[i], ack); check_eq("wdata_ack", ack, 1'b0);
        model_write(wbuf[i]);
      end
    end
    bus_stop();
  endtask

  task automatic read_bytes(input int n);
    logic [7:0] d, e;
    for (int i = 0; i < n; i++) begin
      get_byte(d, (i == n - 1));
      model_read(e);
      check_eq("rd_byte", d, e);
    end
    repeat (3) @(negedge clk);
    check_eq("oe_after_nack", sda_oe, 1'b0);
    bus_stop();
  endtask

  task automatic read_txn(input logic [7:0] p, input int n);
    logic ok, ack;
    addr_phase(7'h1B, 1'b0, ok);
    put_byte(p, ack); check_eq("ptr_ack", ack, 1'b0);
    md_ptr = p;
    addr_phase(7'h1B, 1'b1, ok);
    read_bytes(n);
  endtask

  task automatic post_check();
    repeat (4) @(negedge clk);
    check_eq("speed", speed, md_speed);
    check_eq("config", config_r, md_config);
    check_eq("alert_n", alert_n, model_alert_n());
    check_eq("busy_idle", busy, 1'b0);
    check_eq("oe_idle", sda_oe, 1'b0);
  endtask

  task automatic pulse_alarm(input logic [3:0] m);
    logic pre;
    pre = model_alert_n();
    @(negedge clk) alarm_set = m;
    @(negedge clk) alarm_set = 4'h0;
    md_alarm = md_alarm | m;
    check_eq("alert_pre", alert_n, pre);
    @(negedge clk);
    check_eq("alert_post", alert_n, model_alert_n());
  endtask

  logic [7:0] ptr_tbl [8];
  logic [7:0] rb;
  logic       ok, ack;
  int         oe_before, kind, n;
  logic [6:0] bad;

  initial begin
    ptr_tbl[0] = 8'h00; ptr_tbl[1] = 8'h02; ptr_tbl[2] = 8'h08; ptr_tbl[3] = 8'h0C;
    ptr_tbl[4] = 8'h0E; ptr_tbl[5] = 8'h12; ptr_tbl[6] = 8'h01; ptr_tbl[7] = 8'hFF;
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; alarm_set = 4'h0;
    tach0 = 8'h3F; tach1 = 8'hC4;
    model_reset();
    repeat (5) @(negedge clk);
    check_eq("rst_oe", sda_oe, 1'b0);
    check_eq("rst_alert_n", alert_n, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_speed", speed, 8'h00);
    check_eq("rst_config", config_r, 8'h0A);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset pointer is 0: a bare read returns SPEED
    addr_phase(7'h1B, 1'b1, ok);
    read_bytes(1);
    post_check();

    wbuf[0] = 8'h5C;
    write_txn(7'h1B, 8'h00, 1);
    post_check();
    check_eq("speed_5c", speed, 8'h5C);

    tach0 = 8'h3F;
    read_txn(8'h0C, 1);
    post_check();

    wbuf[0] = 8'h01;
    write_txn(7'h1B, 8'h08, 1);
    post_check();
    pulse_alarm(4'b0001);
    check_eq("alert_low", alert_n, 1'b0);
    read_txn(8'h12, 1);
    post_check();
    check_eq("alert_high", alert_n, 1'b1);
    read_txn(8'h12, 1);
    post_check();

    oe_before = oe_count;
    wbuf[0] = 8'h99;
    write_txn(7'h2C, 8'h00, 1);
    post_check();
    check_eq("bad_addr_no_oe", oe_count - oe_before, 0);

    wbuf[0] = 8'hAA; wbuf[1] = 8'h55;
    write_txn(7'h1B, 8'h00, 2);
    post_check();

    for (int t = 0; t < 20; t++) begin
      tach0 = 8'($urandom); tach1 = 8'($urandom);
      kind = $urandom_range(0, 9);
      n = $urandom_range(1, 3);
      if (kind < 4) begin
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        write_txn(7'h1B, ptr_tbl[$urandom_range(0, 7)], n);
      end else if (kind < 8) begin
        read_txn(ptr_tbl[$urandom_range(0, 7)], n);
      end else if (kind == 8) begin
        pulse_alarm(4'($urandom_range(1, 15)));
      end else begin
        bad = 7'($urandom_range(0, 127));
        if (bad == 7'h1B) bad = 7'h2C;
        oe_before = oe_count;
        addr_phase(bad, 1'($urandom), ok);
        bus_stop();
        check_eq("rand_bad_no_oe", oe_count - oe_before, 0);
      end
      post_check();
    end

    // Asynchronous reset while the target is driving a 0 data bit
    wbuf[0] = 8'h77;
    write_txn(7'h1B, 8'h00, 1);
    wbuf[0] = 8'h33;
    write_txn(7'h1B, 8'h02, 1);
    post_check();
    tach0 = 8'h00;
    addr_phase(7'h1B, 1'b0, ok);
    put_byte(8'h0C, ack);
    addr_phase(7'h1B, 1'b1, ok);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    check_eq("oe_drive0", sda_oe, 1'b1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check_eq("async_rst_oe", sda_oe, 1'b0);
    check_eq("async_rst_speed", speed, 8'h00);
    check_eq("async_rst_config", config_r, 8'h0A);
    check_eq("async_rst_busy", busy, 1'b0);
    check_eq("async_rst_alert", alert_n, 1'b1);
    m_scl = 1'b1; m_sda = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    addr_phase(7'h1B, 1'b1, ok);
    read_bytes(1);
    post_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
